// File: rtl/buffer_verticais.sv
// Output register stage for the vertical sub-pixel filters: saturates 27 signed
// filter results to the unsigned pixel range and registers them with a load enable.
module buffer_verticais #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH+1:0] in_0,  in_1,  in_2,  in_3,  in_4,
                                       in_5,  in_6,  in_7,  in_8,
  input  logic signed [DATA_WIDTH+2:0] in_9,  in_10, in_11, in_12, in_13,
                                       in_14, in_15, in_16, in_17,
  input  logic signed [DATA_WIDTH+1:0] in_18, in_19, in_20, in_21, in_22,
                                       in_23, in_24, in_25, in_26,
  output logic [DATA_WIDTH-1:0]        out_0,  out_1,  out_2,  out_3,  out_4,
                                       out_5,  out_6,  out_7,  out_8,  out_9,
                                       out_10, out_11, out_12, out_13, out_14,
                                       out_15, out_16, out_17, out_18, out_19,
                                       out_20, out_21, out_22, out_23, out_24,
                                       out_25, out_26
);

  localparam int unsigned NCH = 27;
  localparam int unsigned XW  = DATA_WIDTH + 3;

  logic [XW-1:0]         x [NCH];
  logic [DATA_WIDTH-1:0] q [NCH];

  // Groups A/C are sign-extended to the group B width so one saturator covers all
  // channels; sign extension keeps each value, hence each clamp result, unchanged.
  assign x[0]  = {in_0[DATA_WIDTH+1],  in_0};
  assign x[1]  = {in_1[DATA_WIDTH+1],  in_1};
  assign x[2]  = {in_2[DATA_WIDTH+1],  in_2};
  assign x[3]  = {in_3[DATA_WIDTH+1],  in_3};
  assign x[4]  = {in_4[DATA_WIDTH+1],  in_4};
  assign x[5]  = {in_5[DATA_WIDTH+1],  in_5};
  assign x[6]  = {in_6[DATA_WIDTH+1],  in_6};
  assign x[7]  = {in_7[DATA_WIDTH+1],  in_7};
  assign x[8]  = {in_8[DATA_WIDTH+1],  in_8};
  assign x[9]  = in_9;
  assign x[10] = in_10;
  assign x[11] = in_11;
  assign x[12] = in_12;
  assign x[13] = in_13;
  assign x[14] = in_14;
  assign x[15] = in_15;
  assign x[16] = in_16;
  assign x[17] = in_17;
  assign x[18] = {in_18[DATA_WIDTH+1], in_18};
  assign x[19] = {in_19[DATA_WIDTH+1], in_19};
  assign x[20] = {in_20[DATA_WIDTH+1], in_20};
  assign x[21] = {in_21[DATA_WIDTH+1], in_21};
  assign x[22] = {in_22[DATA_WIDTH+1], in_22};
  assign x[23] = {in_23[DATA_WIDTH+1], in_23};
  assign x[24] = {in_24[DATA_WIDTH+1], in_24};
  assign x[25] = {in_25[DATA_WIDTH+1], in_25};
  assign x[26] = {in_26[DATA_WIDTH+1], in_26};

  function automatic logic [DATA_WIDTH-1:0] sat(input logic [XW-1:0] v);
    if (v[XW-1])
      return '0;
    else if (|v[XW-2:DATA_WIDTH])
      return '1;
    else
      return v[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) q[i] <= '0;
    end else if (enable) begin
      for (int unsigned i = 0; i < NCH; i++) q[i] <= sat(x[i]);
    end
  end

  assign out_0  = q[0];
  assign out_1  = q[1];
  assign out_2  = q[2];
  assign out_3  = q[3];
  assign out_4  = q[4];
  assign out_5  = q[5];
  assign out_6  = q[6];
  assign out_7  = q[7];
  assign out_8  = q[8];
  assign out_9  = q[9];
  assign out_10 = q[10];
  assign out_11 = q[11];
  assign out_12 = q[12];
  assign out_13 = q[13];
  assign out_14 = q[14];
  assign out_15 = q[15];
  assign out_16 = q[16];
  assign out_17 = q[17];
  assign out_18 = q[18];
  assign out_19 = q[19];
  assign out_20 = q[20];
  assign out_21 = q[21];
  assign out_22 = q[22];
  assign out_23 = q[23];
  assign out_24 = q[24];
  assign out_25 = q[25];
  assign out_26 = q[26];

endmodule

// File: tb/tb_buffer_verticais.sv
// Bench for buffer_verticais: integer clamp model checked every cycle, plus
// directed literal expectations for reset, pass-through, saturation and gating.
module tb_buffer_verticais;

  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  int            vin [27];
  logic [DW-1:0] o   [27];
  int            expv [27];
  bit            valid = 1'b0;
  int            n_cmp = 0;
  int            n_fail = 0;

  always #5 clock = ~clock;

  buffer_verticais #(.DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_0 (vin[0][DW+1:0]),  .in_1 (vin[1][DW+1:0]),  .in_2 (vin[2][DW+1:0]),
    .in_3 (vin[3][DW+1:0]),  .in_4 (vin[4][DW+1:0]),  .in_5 (vin[5][DW+1:0]),
    .in_6 (vin[6][DW+1:0]),  .in_7 (vin[7][DW+1:0]),  .in_8 (vin[8][DW+1:0]),
    .in_9 (vin[9][DW+2:0]),  .in_10(vin[10][DW+2:0]), .in_11(vin[11][DW+2:0]),
    .in_12(vin[12][DW+2:0]), .in_13(vin[13][DW+2:0]), .in_14(vin[14][DW+2:0]),
    .in_15(vin[15][DW+2:0]), .in_16(vin[16][DW+2:0]), .in_17(vin[17][DW+2:0]),
    .in_18(vin[18][DW+1:0]), .in_19(vin[19][DW+1:0]), .in_20(vin[20][DW+1:0]),
    .in_21(vin[21][DW+1:0]), .in_22(vin[22][DW+1:0]), .in_23(vin[23][DW+1:0]),
    .in_24(vin[24][DW+1:0]), .in_25(vin[25][DW+1:0]), .in_26(vin[26][DW+1:0]),
    .out_0 (o[0]),  .out_1 (o[1]),  .out_2 (o[2]),  .out_3 (o[3]),  .out_4 (o[4]),
    .out_5 (o[5]),  .out_6 (o[6]),  .out_7 (o[7]),  .out_8 (o[8]),  .out_9 (o[9]),
    .out_10(o[10]), .out_11(o[11]), .out_12(o[12]), .out_13(o[13]), .out_14(o[14]),
    .out_15(o[15]), .out_16(o[16]), .out_17(o[17]), .out_18(o[18]), .out_19(o[19]),
    .out_20(o[20]), .out_21(o[21]), .out_22(o[22]), .out_23(o[23]), .out_24(o[24]),
    .out_25(o[25]), .out_26(o[26])
  );

  function automatic int width_of(int k);
    return (k >= 9 && k <= 17) ? DW + 3 : DW + 2;
  endfunction

  // Value the port actually sees: low w bits of the stimulus read as two's complement.
  function automatic int as_signed(int raw, int w);
    int m;
    m = raw & ((1 << w) - 1);
    if (m >= (1 << (w - 1))) m = m - (1 << w);
    return m;
  endfunction

  function automatic int clamp(int v);
    if (v < 0) return 0;
    if (v > (1 << DW) - 1) return (1 << DW) - 1;
    return v;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 27; k++) expv[k] <= 0;
      valid <= 1'b1;
    end else if (enable) begin
      for (int k = 0; k < 27; k++) expv[k] <= clamp(as_signed(vin[k], width_of(k)));
    end
  end

  always @(negedge clock) begin
    if (valid) begin
      for (int k = 0; k < 27; k++) begin
        n_cmp++;
        if (o[k] !== expv[k][DW-1:0]) begin
          n_fail++;
          $display("FAIL model out_%0d: got %0d expected %0d at %0t", k, o[k], expv[k], $time);
        end
      end
    end
  end

  task automatic check_lit(input string name, input int k, input int want);
    n_cmp++;
    if (o[k] !== want[DW-1:0]) begin
      n_fail++;
      $display("FAIL %s out_%0d: got %0d expected %0d", name, k, o[k], want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 27; k++) vin[k] = 100;
    reset = 1'b1; enable = 1'b1;
    tick(); tick();
    for (int k = 0; k < 27; k++) check_lit("reset", k, 0);
    reset = 1'b0; enable = 1'b0;
    tick();
    check_lit("reset_hold", 0, 0); check_lit("reset_hold", 13, 0); check_lit("reset_hold", 26, 0);

    enable = 1'b1;
    for (int k = 0; k < 27; k++) vin[k] = k;
    tick();
    for (int k = 0; k < 27; k++) check_lit("pass", k, k);
    vin[0] = 10; vin[10] = 110; vin[26] = 126;
    tick();
    check_lit("pass2", 0, 10); check_lit("pass2", 10, 110); check_lit("pass2", 26, 126);
    check_lit("pass2", 5, 5);

    vin[1] = 300; vin[20] = 511; vin[5] = 255; vin[2] = 256;
    vin[10] = 310; vin[12] = 1023; vin[13] = 256; vin[11] = 511; vin[15] = 255;
    tick();
    check_lit("sat_hi_a", 1, 255);  check_lit("sat_hi_c", 20, 255);
    check_lit("edge_255", 5, 255);  check_lit("sat_hi_256a", 2, 255);
    check_lit("sat_hi_b", 10, 255); check_lit("sat_hi_b", 12, 255);
    check_lit("sat_hi_256b", 13, 255); check_lit("sat_hi_b511", 11, 255);
    check_lit("edge_255b", 15, 255);

    vin[0] = -5; vin[19] = 519; vin[9] = -1024; vin[3] = -1; vin[14] = -1; vin[22] = -512;
    tick();
    check_lit("sat_lo", 0, 0);  check_lit("sat_lo_519", 19, 0);
    check_lit("sat_lo_min_b", 9, 0); check_lit("sat_lo_m1", 3, 0);
    check_lit("sat_lo_m1b", 14, 0);  check_lit("sat_lo_min_a", 22, 0);

    for (int k = 0; k < 27; k++) vin[k] = 20 + k;
    tick();
    enable = 1'b0;
    for (int k = 0; k < 27; k++) vin[k] = 40 + k;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_lit("hold", 0, 20); check_lit("hold", 9, 29); check_lit("hold", 26, 46);
    end
    enable = 1'b1;
    tick();
    for (int k = 0; k < 27; k++) check_lit("reload", k, 40 + k);

    reset = 1'b1;
    tick();
    for (int k = 0; k < 27; k++) check_lit("reset_mid", k, 0);
    reset = 1'b0;
    tick();
    check_lit("post_reset", 0, 40); check_lit("post_reset", 17, 57); check_lit("post_reset", 26, 66);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_verticais.md
Name: buffer_verticais

Overview:
- Output register stage for the vertical sub-pixel interpolation filters.
- Takes 27 signed filter results and saturates each one to the unsigned pixel range [0, 2^DATA_WIDTH-1].
- Registers the 27 results as DATA_WIDTH-bit pixels, one clock of latency, with a load enable.
- Sits between the vertical filter datapath and the pixel output/packing logic.

Parameters:
- DATA_WIDTH, default 8, pixel bit depth; sets the output width and derives the input widths.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  load enable; when high, outputs are updated on the rising clock edge.
- in_0..in_8  in  DATA_WIDTH+2 each  signed two's-complement filter results, group A.
- in_9..in_17  in  DATA_WIDTH+3 each  signed two's-complement filter results, group B (wider dynamic range).
- in_18..in_26  in  DATA_WIDTH+2 each  signed two's-complement filter results, group C.
- out_0..out_26  out  DATA_WIDTH each  unsigned registered, saturated pixels; out_k corresponds to in_k.

Behaviour:
- Every out_k is a flip-flop output. There is no combinational path from input to output.
- Rising edge with reset=1: all out_k <= 0, regardless of enable. Reset has priority.
- Rising edge with reset=0, enable=1: out_k <= sat(in_k) for all k simultaneously.
- Rising edge with reset=0, enable=0: all out_k hold their value.
- Latency: a value presented before edge N appears on out_k immediately after edge N (1 cycle).
- sat(x), with x interpreted as signed at its own port width:
  - x < 0: result is 0.
  - x > 2^DATA_WIDTH-1: result is 2^DATA_WIDTH-1 (255 for DATA_WIDTH=8).
  - otherwise: result is x[DATA_WIDTH-1:0].
- Saturation is evaluated per input. Group A/C limits come from their DATA_WIDTH+2 width, group B limits from DATA_WIDTH+3.
- Input values never wrap within the block. The saturation comparison uses the sign bit and upper bits of the full input word.
- Channels are fully independent: there is no cross-coupling and no ordering between them.
- Reset asserted mid-stream clears all outputs on that edge. On the first edge after reset deasserts, outputs load only if enable=1.
- No handshake, no internal state beyond the 27 output registers.
- X/undriven inputs when enable=0 are irrelevant, because the held value is kept.

Test Plan:
- Reset: reset=1 for 2 edges with enable=1 and all inputs at 100 -> all out_k = 0. Release reset with enable=0 -> outputs stay 0.
- Pass-through: enable=1, in_k = k for all k (0..26) -> after 1 edge, out_k = k. Then in_0=10, in_10=110, in_26=126 -> next edge gives out_0=10, out_10=110, out_26=126.
- Upper saturation (DATA_WIDTH=8):
  - Group A/C: in_1=300, in_20=511 -> out_1=255, out_20=255. in_5=255 -> out_5=255.
  - Group B: in_10=310 and in_12=1023 -> out_10=255, out_12=255. in_13=256 -> out_13=255.
- Lower saturation:
  - in_0=-5 -> out_0=0.
  - in_19 driven with bit pattern 519 (10-bit, reads as -505) -> out_19=0.
  - in_9=-1024 (11-bit min) -> out_9=0.
  - in_3=-1 -> out_3=0.
- Enable gating: load in_k=20+k with enable=1. Then set enable=0 and change inputs to 40+k for 3 edges -> out_k stays at sat(20+k). Raise enable -> next edge gives out_k = sat(40+k).
- Reset mid-operation: outputs non-zero, assert reset=1 with enable=1 for one edge -> all out_k = 0 that edge. Deassert reset -> next edge loads the current sat(in_k).
